etapa_busqueda: RTL and testbench

//  Instruction-fetch stage directly upstream of the immediate generator and decoder.

---
 rtl/etapa_busqueda.sv | 176 +++++++++++++++++
 tb/tb_etapa_busqueda.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
// Instruction fetch stage: PC, one-outstanding req/ack fetch, PROF-entry buffer toward decode.
// ETAPA_BUSQUEDA_DESALINEO_EN: a misaligned redirect sets sticky desalineo and halts fetch.
module etapa_busqueda #(
  parameter int unsigned     Bits      = 64,
  parameter int unsigned     Ancho     = 32,
  parameter int unsigned     PROF      = 2,
  parameter logic [Bits-1:0] PC_INICIO = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic [Bits-1:0]  mem_addr,
  input  logic             mem_ack,
  input  logic [Ancho-1:0] mem_rdata,
  input  logic             salto_valido,
  input  logic [Bits-1:0]  salto_destino,
  output logic             inst_valida,
  input  logic             inst_ready,
  output logic [Ancho-1:0] Instruccion,
`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
  output logic             desalineo,
`endif
  output logic [Bits-1:0]  PC_inst
);

  localparam int unsigned PW = $clog2(PROF);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] LLENO = CW'(PROF);

  localparam logic [1:0] ARRANQUE = 2'd0;
  localparam logic [1:0] PIDE     = 2'd1;
  localparam logic [1:0] DESCARTA = 2'd2;

  logic [1:0]       estado_q, estado_d;
  logic [Bits-1:0]  pc_q, pc_d;
  logic [Bits-1:0]  dir_vieja_q, dir_vieja_d;
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [Ancho-1:0] inst_ult_q;
  logic [Bits-1:0]  pc_ult_q;
  logic [Ancho-1:0] inst_mem [PROF];
  logic [Bits-1:0]  pc_mem   [PROF];

  logic            detenido;
  logic            ack_ok;
  logic            push;
  logic            pop;
  logic [Bits-1:0] destino;

`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
  localparam logic [Bits-1:0] PC_RESET = PC_INICIO;
  logic desal_q;

  assign desalineo = desal_q;
  assign detenido  = desal_q;
  assign destino   = salto_destino;

  always_ff @(posedge clk) begin
    if (reset) begin
      desal_q <= 1'b0;
    end else if (salto_valido && (salto_destino[1:0] != 2'b00)) begin
      desal_q <= 1'b1;
    end
  end
`else
  // Without the check, the PC is kept word aligned so mem_addr[1:0] is always zero.
  localparam logic [Bits-1:0] PC_RESET = {PC_INICIO[Bits-1:2], 2'b00};
  logic unused_bajo;

  assign unused_bajo = ^salto_destino[1:0];
  assign detenido    = 1'b0;
  assign destino     = {salto_destino[Bits-1:2], 2'b00};
`endif

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (estado_q)
      PIDE: begin
        mem_req  = (cuenta_q < LLENO) && !detenido;
        mem_addr = pc_q;
      end
      DESCARTA: begin
        mem_req  = 1'b1;
        mem_addr = dir_vieja_q;
      end
      default: ;
    endcase
  end

  assign ack_ok      = mem_req & mem_ack;
  assign push        = (estado_q == PIDE) && ack_ok && !salto_valido;
  assign inst_valida = (cuenta_q != '0);
  assign pop         = inst_valida && inst_ready && !salto_valido;
  assign Instruccion = inst_valida ? inst_mem[rd_q] : inst_ult_q;
  assign PC_inst     = inst_valida ? pc_mem[rd_q]   : pc_ult_q;

  always_comb begin
    estado_d    = estado_q;
    pc_d        = pc_q;
    dir_vieja_d = dir_vieja_q;
    case (estado_q)
      ARRANQUE: begin
        estado_d = PIDE;
        if (salto_valido) pc_d = destino;
      end
      PIDE: begin
        if (ack_ok) begin
          pc_d = salto_valido ? destino : pc_q + Bits'(4);
        end else if (salto_valido) begin
          pc_d = destino;
          // The request already on the bus must complete; remember its address to hold it.
          if (mem_req) begin
            estado_d    = DESCARTA;
            dir_vieja_d = pc_q;
          end
        end
      end
      DESCARTA: begin
        if (salto_valido) pc_d = destino;
        if (mem_ack) estado_d = PIDE;
      end
      default: estado_d = ARRANQUE;
    endcase
  end

  always_comb begin
    cuenta_d = cuenta_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    if (salto_valido) begin
      cuenta_d = '0;
      rd_d     = '0;
      wr_d     = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop) begin
        cuenta_d = cuenta_q + CW'(1);
      end else if (pop && !push) begin
        cuenta_d = cuenta_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= ARRANQUE;
      pc_q        <= PC_RESET;
      dir_vieja_q <= '0;
      cuenta_q    <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      inst_ult_q  <= '0;
      pc_ult_q    <= '0;
    end else begin
      estado_q    <= estado_d;
      pc_q        <= pc_d;
      dir_vieja_q <= dir_vieja_d;
      cuenta_q    <= cuenta_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      // Remember what was last presented so an empty buffer keeps showing it.
      inst_ult_q  <= Instruccion;
      pc_ult_q    <= PC_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= mem_rdata;
      pc_mem[wr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: streaming, backpressure, slow ack, redirects, wrap, alignment.
module tb_etapa_busqueda;

  localparam int Bits  = 64;
  localparam int Ancho = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_req;
  logic [Bits-1:0]  mem_addr;
  logic             mem_ack;
  logic [Ancho-1:0] mem_rdata;
  logic             salto_valido;
  logic [Bits-1:0]  salto_destino;
  logic             inst_valida;
  logic             inst_ready;
  logic [Ancho-1:0] Instruccion;
  logic [Bits-1:0]  PC_inst;
`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
  logic             desalineo;
`endif

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  etapa_busqueda #(.Bits(Bits), .Ancho(Ancho), .PROF(2), .PC_INICIO('0)) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .salto_valido(salto_valido),
    .salto_destino(salto_destino),
    .inst_valida(inst_valida),
    .inst_ready(inst_ready),
    .Instruccion(Instruccion),
`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
    .desalineo(desalineo),
`endif
    .PC_inst(PC_inst)
  );

  function automatic logic [31:0] w(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    salto_valido = 1'b0; salto_destino = '0; inst_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    salto_valido = 1'b0; salto_destino = '0; inst_ready = 1'b0;
    tick(); tick();
    n_eval++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    n_eval++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL reset_valida: got %b expected 0", inst_valida); end
    n_eval++; if (Instruccion !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", Instruccion); end
    n_eval++; if (PC_inst !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PC_inst); end
`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
    n_eval++; if (desalineo !== 1'b0) begin n_fail++; $display("FAIL reset_desal: got %b expected 0", desalineo); end
`endif
  endtask

  task automatic test_stream;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_eval++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %b expected 1", k, mem_req); end
      n_eval++; if (mem_addr !== 64'(4 * k)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, mem_addr, 64'(4 * k)); end
      if (k > 0) begin
        n_eval++; if (inst_valida !== 1'b1) begin n_fail++; $display("FAIL stream_valida[%0d]: got %b expected 1", k, inst_valida); end
        n_eval++; if (Instruccion !== w(64'(4 * (k - 1)))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, Instruccion, w(64'(4 * (k - 1)))); end
        n_eval++; if (PC_inst !== 64'(4 * (k - 1))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, PC_inst, 64'(4 * (k - 1))); end
      end
      mem_ack = 1'b1; mem_rdata = w(64'(4 * k));
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_rdata = w(64'(4 * k));
      tick();
    end
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_eval++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req[%0d]: got %b expected 0", k, mem_req); end
      n_eval++; if (Instruccion !== w(64'h0)) begin n_fail++; $display("FAIL full_inst[%0d]: got %h expected %h", k, Instruccion, w(64'h0)); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_eval++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_after_pop: got %b expected 1", mem_req); end
    n_eval++; if (mem_addr !== 64'h8) begin n_fail++; $display("FAIL bp_addr_after_pop: got %h expected 8", mem_addr); end
    n_eval++; if (PC_inst !== 64'h4) begin n_fail++; $display("FAIL bp_pc_after_pop: got %h expected 4", PC_inst); end
    n_eval++; if (Instruccion !== w(64'h4)) begin n_fail++; $display("FAIL bp_inst_after_pop: got %h expected %h", Instruccion, w(64'h4)); end
    mem_ack = 1'b1; mem_rdata = w(64'h8);
    tick();
    mem_ack = 1'b0;
    n_eval++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_refull_req: got %b expected 0", mem_req); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_eval++; if (Instruccion !== w(64'h8)) begin n_fail++; $display("FAIL bp_third_inst: got %h expected %h", Instruccion, w(64'h8)); end
    n_eval++; if (PC_inst !== 64'h8) begin n_fail++; $display("FAIL bp_third_pc: got %h expected 8", PC_inst); end
  endtask

  task automatic test_delayed_ack;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_eval++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL slow_req[%0d]: got %b expected 1", k, mem_req); end
      n_eval++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL slow_addr[%0d]: got %h expected 0", k, mem_addr); end
      n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL slow_valida[%0d]: got %b expected 0", k, inst_valida); end
      mem_ack = (k == 3); mem_rdata = w(64'h0);
      tick();
    end
    mem_ack = 1'b0;
    n_eval++; if (inst_valida !== 1'b1) begin n_fail++; $display("FAIL slow_push_valida: got %b expected 1", inst_valida); end
    n_eval++; if (mem_addr !== 64'h4) begin n_fail++; $display("FAIL slow_next_addr: got %h expected 4", mem_addr); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL slow_single_push: got %b expected 0", inst_valida); end
  endtask

  task automatic test_redirect_outstanding;
    do_reset();
    inst_ready = 1'b1;
    mem_ack = 1'b1; mem_rdata = w(64'h0);
    tick();
    mem_ack = 1'b0; salto_valido = 1'b1; salto_destino = 64'h100;
    tick();
    salto_valido = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_eval++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL desc_req[%0d]: got %b expected 1", k, mem_req); end
      n_eval++; if (mem_addr !== 64'h4) begin n_fail++; $display("FAIL desc_addr[%0d]: got %h expected 4", k, mem_addr); end
      n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL desc_valida[%0d]: got %b expected 0", k, inst_valida); end
      mem_ack = (k == 1); mem_rdata = w(64'h4);
      tick();
    end
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL desc_dropped: got %b expected 0", inst_valida); end
    n_eval++; if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL desc_target_addr: got %h expected 100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = w(64'h100);
    tick();
    mem_ack = 1'b0;
    n_eval++; if (Instruccion !== w(64'h100)) begin n_fail++; $display("FAIL desc_target_inst: got %h expected %h", Instruccion, w(64'h100)); end
    n_eval++; if (PC_inst !== 64'h100) begin n_fail++; $display("FAIL desc_target_pc: got %h expected 100", PC_inst); end
    n_eval++; if (mem_addr !== 64'h104) begin n_fail++; $display("FAIL desc_follow_addr: got %h expected 104", mem_addr); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_full;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_rdata = w(64'(4 * k));
      tick();
    end
    inst_ready = 1'b1; salto_valido = 1'b1; salto_destino = 64'h200;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    salto_valido = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL flush_valida: got %b expected 0", inst_valida); end
    n_eval++; if (mem_addr !== 64'h200) begin n_fail++; $display("FAIL flush_addr: got %h expected 200", mem_addr); end
    n_eval++; if (Instruccion !== w(64'h0)) begin n_fail++; $display("FAIL flush_hold_inst: got %h expected %h", Instruccion, w(64'h0)); end
    tick();
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL flush_no_push: got %b expected 0", inst_valida); end
    mem_ack = 1'b1; mem_rdata = w(64'h200);
    tick();
    mem_ack = 1'b0;
    n_eval++; if (PC_inst !== 64'h200) begin n_fail++; $display("FAIL flush_target_pc: got %h expected 200", PC_inst); end
  endtask

  task automatic test_wrap;
    do_reset();
    mem_ack = 1'b1; mem_rdata = w(64'h0);
    salto_valido = 1'b1; salto_destino = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    salto_valido = 1'b0;
    n_eval++; if (inst_valida !== 1'b0) begin n_fail++; $display("FAIL wrap_drop: got %b expected 0", inst_valida); end
    n_eval++; if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_top: got %h expected fffffffffffffffc", mem_addr); end
    mem_rdata = w(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    mem_ack = 1'b0;
    n_eval++; if (PC_inst !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h expected fffffffffffffffc", PC_inst); end
    n_eval++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_addr_zero: got %h expected 0", mem_addr); end
  endtask

  task automatic test_misaligned;
    do_reset();
`ifdef ETAPA_BUSQUEDA_DESALINEO_EN
    mem_ack = 1'b1; mem_rdata = w(64'h0);
    salto_valido = 1'b1; salto_destino = 64'h102;
    tick();
    salto_valido = 1'b0; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_eval++; if (desalineo !== 1'b1) begin n_fail++; $display("FAIL desal_sticky[%0d]: got %b expected 1", k, desalineo); end
      n_eval++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL desal_halt[%0d]: got %b expected 0", k, mem_req); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_eval++; if (desalineo !== 1'b0) begin n_fail++; $display("FAIL desal_reset: got %b expected 0", desalineo); end
`else
    mem_ack = 1'b1; mem_rdata = w(64'h0);
    salto_valido = 1'b1; salto_destino = 64'h102;
    tick();
    salto_valido = 1'b0;
    n_eval++; if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL align_addr: got %h expected 100", mem_addr); end
    mem_rdata = w(64'h100);
    tick();
    mem_ack = 1'b0;
    n_eval++; if (PC_inst !== 64'h100) begin n_fail++; $display("FAIL align_pc: got %h expected 100", PC_inst); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_delayed_ack();
    test_redirect_outstanding();
    test_redirect_full();
    test_wrap();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
